// File: rtl/join_match_ctrl.sv
// Matching store for the JOIN stage: pairs L/R tokens that share a key and parks
// unmatched tokens in the lowest free entry until their partner arrives.
module join_match_ctrl #(
  parameter int NENT = 4,
  parameter int DW   = 16,
  parameter int CW   = 3
) (
  input  logic          CP,
  input  logic          MR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [18:0]   IN_TAG,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [17:0]   OUT_KEY,
  output logic [DW-1:0] OUT_DATA_L,
  output logic [DW-1:0] OUT_DATA_R,
  output logic [CW-1:0] OCCUPANCY,
  output logic          FULL
);

  localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;

  typedef enum logic {OUT_EMPTY, OUT_HELD} out_state_t;

  logic [NENT-1:0] wait_reg;
  logic [NENT-1:0] lr_reg;
  logic [17:0]     key_reg  [NENT];
  logic [DW-1:0]   data_reg [NENT];

  out_state_t      out_state_reg;
  logic [17:0]     out_key_reg;
  logic [DW-1:0]   out_data_l_reg;
  logic [DW-1:0]   out_data_r_reg;
  logic [CW-1:0]   occ_reg;

  logic [NENT-1:0] hit;
  logic [IW-1:0]   hit_idx;
  logic [IW-1:0]   free_idx;
  logic            any_hit;
  logic            any_free;
  logic            out_free;
  logic            accept;
  logic            fire;
  logic            alloc;

  genvar gi;
  generate
    for (gi = 0; gi < NENT; gi++) begin : g_match
      assign hit[gi] = wait_reg[gi] && (key_reg[gi] == IN_TAG[18:1]) && (lr_reg[gi] != IN_TAG[0]);
    end
  endgenerate

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (hit[i])       hit_idx  = IW'(i);
      if (!wait_reg[i]) free_idx = IW'(i);
    end
  end

  assign any_hit  = |hit;
  assign any_free = ~&wait_reg;
  assign out_free = (out_state_reg == OUT_EMPTY) || OUT_READY;
  assign IN_READY = !MR && (any_hit ? out_free : any_free);
  assign accept   = IN_VALID && IN_READY;
  assign fire     = accept && any_hit;
  assign alloc    = accept && !any_hit;

  always_ff @(posedge CP) begin
    if (MR) begin
      wait_reg       <= '0;
      out_state_reg  <= OUT_EMPTY;
      out_key_reg    <= '0;
      out_data_l_reg <= '0;
      out_data_r_reg <= '0;
      occ_reg        <= '0;
    end else begin
      if (out_state_reg == OUT_HELD && OUT_READY)
        out_state_reg <= OUT_EMPTY;
      if (fire) begin
        out_state_reg       <= OUT_HELD;
        out_key_reg         <= IN_TAG[18:1];
        wait_reg[hit_idx]   <= 1'b0;
        occ_reg             <= occ_reg - 1'b1;
        // The stored token keeps its own side; the incoming token fills the other.
        if (lr_reg[hit_idx]) begin
          out_data_l_reg <= IN_DATA;
          out_data_r_reg <= data_reg[hit_idx];
        end else begin
          out_data_l_reg <= data_reg[hit_idx];
          out_data_r_reg <= IN_DATA;
        end
      end else if (alloc) begin
        wait_reg[free_idx] <= 1'b1;
        occ_reg            <= occ_reg + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: it is only observed through a WAIT entry.
  always_ff @(posedge CP) begin
    if (alloc) begin
      key_reg[free_idx]  <= IN_TAG[18:1];
      lr_reg[free_idx]   <= IN_TAG[0];
      data_reg[free_idx] <= IN_DATA;
    end
  end

  assign OUT_VALID  = (out_state_reg == OUT_HELD);
  assign OUT_KEY    = out_key_reg;
  assign OUT_DATA_L = out_data_l_reg;
  assign OUT_DATA_R = out_data_r_reg;
  assign OCCUPANCY  = occ_reg;
  assign FULL       = (occ_reg == CW'(NENT));

endmodule

// File: tb/tb_join_match_ctrl.sv
// Self-checking bench for join_match_ctrl: reference model of the store plus a
// scoreboard of expected fired pairs, checked every cycle while OUT_VALID is high.
module tb_join_match_ctrl;

  localparam int NENT = 4;
  localparam int DW   = 16;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          mr = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [18:0]   in_tag = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [17:0]   out_key;
  logic [DW-1:0] out_data_l;
  logic [DW-1:0] out_data_r;
  logic [CW-1:0] occupancy;
  logic          full;

  always #5 clk = ~clk;

  join_match_ctrl #(.NENT(NENT), .DW(DW), .CW(CW)) dut (
    .CP(clk), .MR(mr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_TAG(in_tag), .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_KEY(out_key), .OUT_DATA_L(out_data_l), .OUT_DATA_R(out_data_r),
    .OCCUPANCY(occupancy), .FULL(full)
  );

  typedef struct packed {
    logic [17:0]   key;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t sb[$];

  bit            m_wait [NENT];
  logic [17:0]   m_key  [NENT];
  logic          m_lr   [NENT];
  logic [DW-1:0] m_data [NENT];
  int            m_occ = 0;
  bit            m_ov  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  bit acc;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_wait[i] = 1'b0;
    m_occ = 0;
    m_ov  = 1'b0;
    sb.delete();
  endtask

  // One clock: check outputs against the model, then advance model and DUT together.
  task automatic cycle();
    int    hi;
    int    fi;
    bit    exp_ready;
    pair_t p;
    #1;
    hi = -1;
    fi = -1;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (m_wait[i] && m_key[i] == in_tag[18:1] && m_lr[i] != in_tag[0]) hi = i;
      if (!m_wait[i]) fi = i;
    end
    exp_ready = !mr && ((hi >= 0) ? (!m_ov || out_ready) : (fi >= 0));
    check_val("in_ready", 64'(in_ready), 64'(exp_ready));
    check_val("out_valid", 64'(out_valid), 64'(m_ov));
    check_val("occupancy", 64'(occupancy), 64'(m_occ));
    check_val("full", 64'(full), 64'(m_occ == NENT));
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        check_val("out_key", 64'(out_key), 64'(sb[0].key));
        check_val("out_data_l", 64'(out_data_l), 64'(sb[0].l));
        check_val("out_data_r", 64'(out_data_r), 64'(sb[0].r));
      end
    end
    acc = in_valid && in_ready;
    @(posedge clk);
    if (mr) begin
      model_reset();
    end else begin
      if (m_ov && out_ready) begin
        m_ov = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (acc && exp_ready) begin
        if (hi >= 0) begin
          p.key = in_tag[18:1];
          p.l   = m_lr[hi] ? in_data : m_data[hi];
          p.r   = m_lr[hi] ? m_data[hi] : in_data;
          sb.push_back(p);
          m_ov       = 1'b1;
          m_wait[hi] = 1'b0;
          m_occ--;
        end else begin
          m_wait[fi] = 1'b1;
          m_key[fi]  = in_tag[18:1];
          m_lr[fi]   = in_tag[0];
          m_data[fi] = in_data;
          m_occ++;
        end
      end
    end
    #1;
  endtask

  task automatic send(input logic [17:0] key, input logic lr, input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_tag   = {key, lr};
    in_data  = data;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle();
    if (!acc) check_val("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    model_reset();
    // 1. reset
    mr = 1'b1;
    idle(2);
    mr = 1'b0;
    idle(1);
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_occupancy", 64'(occupancy), 64'(0));
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    check_val("rst_out_key", 64'(out_key), 64'(0));
    check_val("rst_out_data", 64'({out_data_l, out_data_r}), 64'(0));

    // 2. basic L/R pair
    send(18'h00A5, 1'b0, 16'h1111);
    check_val("t2_occ1", 64'(occupancy), 64'(1));
    send(18'h00A5, 1'b1, 16'h2222);
    check_val("t2_valid", 64'(out_valid), 64'(1));
    check_val("t2_key", 64'(out_key), 64'(18'h00A5));
    check_val("t2_l", 64'(out_data_l), 64'(16'h1111));
    check_val("t2_r", 64'(out_data_r), 64'(16'h2222));
    check_val("t2_occ0", 64'(occupancy), 64'(0));
    idle(2);

    // 3. fill, backpressure, then hitting token accepted while full
    for (int i = 0; i < NENT; i++) send(18'h10 + 18'(i), 1'b0, 16'hA000 + 16'(i));
    check_val("t3_full", 64'(full), 64'(1));
    in_valid = 1'b1;
    in_tag   = {18'h20, 1'b0};
    in_data  = 16'hDEAD;
    idle(2);
    check_val("t3_blocked", 64'(in_ready), 64'(0));
    send(18'h12, 1'b1, 16'hB002);
    check_val("t3_full_drop", 64'(full), 64'(0));
    check_val("t3_pair_l", 64'(out_data_l), 64'(16'hA002));
    send(18'h10, 1'b1, 16'hB000);
    send(18'h11, 1'b1, 16'hB001);
    send(18'h13, 1'b1, 16'hB003);
    idle(2);

    // 4. two waiting K=3 L at entries 0 and 2: entry 0 fires first
    send(18'h3, 1'b0, 16'hC000);
    send(18'h40, 1'b0, 16'hC001);
    send(18'h3, 1'b0, 16'hC002);
    send(18'h40, 1'b1, 16'hD001);
    idle(1);
    send(18'h3, 1'b1, 16'hD000);
    check_val("t4_l_from_entry0", 64'(out_data_l), 64'(16'hC000));
    check_val("t4_occ", 64'(occupancy), 64'(1));
    idle(1);

    // 5. stalled output blocks a hitting token; release lets the second pair through
    send(18'h50, 1'b0, 16'hE000);
    out_ready = 1'b0;
    send(18'h3, 1'b1, 16'hD002);
    in_valid = 1'b1;
    in_tag   = {18'h50, 1'b1};
    in_data  = 16'hE001;
    idle(3);
    check_val("t5_stall_ready", 64'(in_ready), 64'(0));
    check_val("t5_stall_l", 64'(out_data_l), 64'(16'hC002));
    out_ready = 1'b1;
    idle(1);
    in_valid = 1'b0;
    check_val("t5_second_key", 64'(out_key), 64'(18'h50));
    check_val("t5_second_r", 64'(out_data_r), 64'(16'hE001));
    idle(2);

    // 6. reset with waiting entries and a held pair
    send(18'h60, 1'b0, 16'h6000);
    send(18'h61, 1'b0, 16'h6001);
    send(18'h70, 1'b0, 16'h7000);
    out_ready = 1'b0;
    send(18'h70, 1'b1, 16'h7001);
    send(18'h62, 1'b0, 16'h6002);
    check_val("t6_pre_valid", 64'(out_valid), 64'(1));
    mr = 1'b1;
    idle(1);
    mr = 1'b0;
    out_ready = 1'b1;
    check_val("t6_cleared_occ", 64'(occupancy), 64'(0));
    check_val("t6_cleared_valid", 64'(out_valid), 64'(0));
    send(18'h60, 1'b1, 16'h6100);
    check_val("t6_parked", 64'(occupancy), 64'(1));
    check_val("t6_no_fire", 64'(out_valid), 64'(0));
    idle(2);
    check_val("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
